stack_cpu: RTL and testbench
============================

STACK_CPU -- requirements
Module: stack_cpu

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data and stack entry width (minimum 4).
REQ-002 SHALL have parameter DEPTH, default 16, meaning stack entries (minimum 2).
REQ-003 SHALL have parameter PCW, default 8, meaning program counter width (PCW <= DW).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port imem_req  output  1  meaning instruction fetch request.
REQ-007 SHALL have port imem_addr  output  PCW  meaning fetch address, equal to the current PC.
REQ-008 SHALL have port imem_ack  input  1  meaning the fetch data is valid this cycle.
REQ-009 SHALL have port imem_data  input  DW+1  meaning the instruction word.
REQ-010 SHALL have port done  output  1  meaning the core has stopped, whether by halt or by fault.
REQ-011 SHALL have port fault  output  1  meaning the core stopped on a stack overflow or underflow.
REQ-012 SHALL have port tos  output  DW  meaning top-of-stack value, 0 when the stack is empty.
REQ-013 SHALL have port depth  output  $clog2(DEPTH+1)  meaning current entry count.

Function
REQ-014 SHALL decode instructions as follows: bit[DW]=0 is PUSH of immediate bits[DW-1:0]; an all-ones word is HALT; otherwise bits[3:0] select the operation.
REQ-015 SHALL support these operation codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 DUP, 6 DROP, 7 SWAP, 8 BRZ; codes 9-15 are NOP.
REQ-016 SHALL, for the binary ops ADD, SUB, AND, OR and XOR, pop two operands and push one result.
- Operand A is the second entry; operand B is the top.
- SUB computes A-B.
- Results wrap modulo 2^DW.
REQ-017 SHALL execute DUP by pushing a copy of the top, DROP by popping one entry, and SWAP by exchanging the top two entries.
REQ-018 SHALL execute BRZ by popping the target (top, low PCW bits) and then the condition (second entry).
- PC loads the target if the condition equals 0.
- Otherwise PC becomes PC+1.
REQ-019 SHALL advance PC to PC+1 for every non-branching instruction, wrapping modulo 2^PCW.
REQ-020 SHALL implement the FSM states FETCH, EXEC, HALT and FAULT.
REQ-021 SHALL assert imem_req in FETCH, hold imem_addr stable until imem_ack, latch imem_data on the ack cycle, and then go to EXEC.
REQ-022 SHALL stay in FETCH without limit while imem_ack is low; an imem_ack seen outside FETCH SHALL be ignored.
REQ-023 SHALL complete EXEC in one cycle.
- The next state is FETCH.
- On HALT the next state is HALT.
- On a stack error the next state is FAULT.
REQ-024 SHALL detect these stack errors:
- Overflow: PUSH or DUP while depth==DEPTH.
- Underflow: a binary op, SWAP or BRZ while depth<2.
- Underflow: DUP or DROP while depth==0.
REQ-025 SHALL leave the stack, depth and PC unchanged by a faulting instruction.
REQ-026 SHALL make HALT and FAULT terminal until reset, with imem_req=0, done=1, and fault=1 only in FAULT.
REQ-027 SHALL give best-case throughput of one instruction per two cycles (ack in the first FETCH cycle).

Reset
REQ-028 SHALL, while reset is low, force state=FETCH, PC=0, depth=0, tos=0, done=0, fault=0, imem_req=0, with stack storage contents don't-care.
REQ-029 SHALL start a fetch of address 0 on the first clk edge after reset deasserts.
REQ-030 SHALL, when reset is asserted mid-fetch or mid-exec, abandon the instruction with no partial stack or PC update.

Structure
REQ-031 SHALL place the opcode enum, the FSM state enum and the HALT encoding in a shared package.
REQ-032 SHALL implement storage in one sub-module, stack_mem.
- Parameters: DW and DEPTH.
- Inputs: push, pop1, pop2, wdata.
- Outputs: top, second, count.
- Replacement semantics: pop-and-push in one cycle.
REQ-033 SHALL use combinational ALU and control logic in stack_cpu; the only registers are PC, instruction, state and the stack.

Verification
REQ-034 SHALL cover ADD with a 1-cycle-ack memory: PUSH 5, PUSH 7, ADD, HALT -> tos=12, depth=1, done=1, fault=0, within 8 cycles.
REQ-035 SHALL cover wrap and order at DW=8: PUSH 3, PUSH 5, SUB -> tos=254; PUSH 200, PUSH 100, ADD -> tos=44.
REQ-036 SHALL cover overflow at DEPTH=4: five PUSH 1 -> after the fifth, fault=1, done=1, depth=4, PC=4.
REQ-037 SHALL cover underflow and a taken branch:
- Program with PUSH 9, then ADD -> fault=1, depth=1, tos=9.
- Program with PUSH 0, PUSH 6, BRZ -> PC=6, depth=0.
REQ-038 SHALL cover stall and reset:
- Ack delayed 5 cycles -> imem_addr stable, with exactly one instruction executed.
- Reset pulsed low in EXEC -> PC=0, depth=0, done=0, with a refetch of address 0.

Source files
------------

// File: rtl/stack_cpu_pkg.sv
// Shared encodings for the stack CPU: opcodes, control states and the HALT word.
package stack_cpu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_DUP  = 4'd5,
      OP_DROP = 4'd6,
      OP_SWAP = 4'd7,
      OP_BRZ  = 4'd8
   } opcode_e;

   typedef enum logic [1:0] {
      S_FETCH,
      S_EXEC,
      S_HALT,
      S_FAULT
   } state_e;

   // HALT is the all-ones instruction word; users take the low DW+1 bits.
   localparam logic [63:0] HALT_WORD = '1;

endpackage

// File: rtl/stack_mem.sv
// Register-file stack with push/pop1/pop2 and in-place replacement when a pop and
// a push land in the same cycle; swap exchanges the two top entries.
module stack_mem
   import stack_cpu_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop1,
   input  logic                       pop2,
   input  logic                       swap,
   input  logic [DW-1:0]              wdata,
   output logic [DW-1:0]              top,
   output logic [DW-1:0]              second,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] i_top, i_sec, i_new;

   assign i_top = AW'(count - CW'(1));
   assign i_sec = AW'(count - CW'(2));
   assign i_new = AW'(count);

   // Empty slots read as zero so the visible top-of-stack is clean.
   assign top    = (count != '0)       ? mem[i_top] : '0;
   assign second = (count >= CW'(2))   ? mem[i_sec] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (pop2) begin
         count <= count - (push ? CW'(1) : CW'(2));
      end else if (pop1) begin
         count <= push ? count : count - CW'(1);
      end else if (push) begin
         count <= count + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (swap) begin
         mem[i_top] <= second;
         mem[i_sec] <= top;
      end else if (push) begin
         if (pop2)      mem[i_sec] <= wdata;
         else if (pop1) mem[i_top] <= wdata;
         else           mem[i_new] <= wdata;
      end
   end

endmodule

// File: rtl/stack_cpu.sv
// Two-phase (fetch, execute) stack machine; ALU and decode are combinational and
// only PC, instruction, state and the stack hold state.
module stack_cpu
   import stack_cpu_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 16,
   parameter int PCW   = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       imem_req,
   output logic [PCW-1:0]             imem_addr,
   input  logic                       imem_ack,
   input  logic [DW:0]                imem_data,
   output logic                       done,
   output logic                       fault,
   output logic [DW-1:0]              tos,
   output logic [$clog2(DEPTH+1)-1:0] depth
);

   localparam int CW = $clog2(DEPTH+1);

   state_e          state;
   logic [PCW-1:0]  pc, pc_next;
   logic [DW:0]     instr;
   logic [DW-1:0]   top, second, wdata, alu;
   logic [CW-1:0]   count;
   opcode_e         op;
   logic            is_push, is_halt, has1, has2, full, run;
   logic            push, pop1, pop2, swap, err;

   assign is_push = !instr[DW];
   assign is_halt = (instr == HALT_WORD[DW:0]);
   assign op      = opcode_e'(instr[3:0]);
   assign has1    = (count != '0);
   assign has2    = (count >= CW'(2));
   assign full    = (count == CW'(DEPTH));

   always_comb begin
      case (op)
         OP_SUB:  alu = second - top;
         OP_AND:  alu = second & top;
         OP_OR:   alu = second | top;
         OP_XOR:  alu = second ^ top;
         default: alu = second + top;
      endcase
   end

   // Raw stack intent and error for the latched instruction; gated by 'run' below.
   always_comb begin
      push    = 1'b0;
      pop1    = 1'b0;
      pop2    = 1'b0;
      swap    = 1'b0;
      err     = 1'b0;
      wdata   = instr[DW-1:0];
      pc_next = pc + PCW'(1);
      if (is_push) begin
         push = 1'b1;
         err  = full;
      end else if (!is_halt) begin
         case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
               push  = 1'b1;
               pop2  = 1'b1;
               wdata = alu;
               err   = !has2;
            end
            OP_DUP: begin
               push  = 1'b1;
               wdata = top;
               err   = full || !has1;
            end
            OP_DROP: begin
               pop1 = 1'b1;
               err  = !has1;
            end
            OP_SWAP: begin
               swap = 1'b1;
               err  = !has2;
            end
            OP_BRZ: begin
               pop2 = 1'b1;
               err  = !has2;
               if (second == '0) pc_next = top[PCW-1:0];
            end
            default: ;
         endcase
      end
   end

   assign run = (state == S_EXEC) && !err && !is_halt;

   stack_mem #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk    (clk),
      .reset  (reset),
      .push   (push && run),
      .pop1   (pop1 && run),
      .pop2   (pop2 && run),
      .swap   (swap && run),
      .wdata  (wdata),
      .top    (top),
      .second (second),
      .count  (count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_FETCH;
         pc    <= '0;
         instr <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (imem_ack) begin
                  instr <= imem_data;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_halt) begin
                  state <= S_HALT;
               end else if (err) begin
                  state <= S_FAULT;
               end else begin
                  pc    <= pc_next;
                  state <= S_FETCH;
               end
            end
            default: ;
         endcase
      end
   end

   // Request is masked by reset so nothing is fetched while held in reset.
   assign imem_req  = reset && (state == S_FETCH);
   assign imem_addr = pc;
   assign done      = (state == S_HALT) || (state == S_FAULT);
   assign fault     = (state == S_FAULT);
   assign tos       = top;
   assign depth     = count;

endmodule

// File: tb/tb_stack_cpu.sv
// Randomized and directed programs against an ISA-level model; a monitor scores
// every fetch address and the final machine state.
module tb_stack_cpu;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int PCW   = 8;
   localparam int CW    = $clog2(DEPTH+1);

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           imem_req;
   logic [PCW-1:0] imem_addr;
   logic           imem_ack = 1'b0;
   logic [DW:0]    imem_data = '0;
   logic           done, fault;
   logic [DW-1:0]  tos;
   logic [CW-1:0]  depth;

   always #5 clk = ~clk;

   stack_cpu #(.DW(DW), .DEPTH(DEPTH), .PCW(PCW)) dut (
      .clk       (clk),
      .reset     (reset),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_data (imem_data),
      .done      (done),
      .fault     (fault),
      .tos       (tos),
      .depth     (depth)
   );

   typedef struct {
      int tos;
      int depth;
      int pc;
      int fault;
   } final_t;

   logic [DW:0] prog [256];
   int          exp_addr_q[$];
   final_t      fin_q[$];
   int          tests = 0;
   int          fails = 0;
   bit          mon_en = 0;
   bit          spur = 1;
   int          fixed_lat = -1;
   int          max_lat = 3;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [DW:0] psh(input int v);
      logic [DW:0] w;
      w = '0;
      w[DW-1:0] = DW'(v);
      return w;
   endfunction

   function automatic logic [DW:0] opw(input int op);
      logic [DW:0] w;
      w = '0;
      w[DW] = 1'b1;
      w[3:0] = 4'(op);
      return w;
   endfunction

   // Instruction-set interpreter over a queue stack.
   task automatic run_model(input bit commit, output bit ok);
      int s[$];
      int a[$];
      int pc, nxt, op, x, y, r;
      bit hlt, flt;
      logic [DW:0] w;
      final_t f;
      pc = 0; hlt = 0; flt = 0; ok = 0;
      for (int step = 0; step < 80 && !hlt && !flt; step++) begin
         w = prog[pc];
         a.push_back(pc);
         nxt = (pc + 1) % 256;
         if (w[DW] == 1'b0) begin
            if (s.size() == DEPTH) flt = 1;
            else s.push_back(int'(w[DW-1:0]));
         end else if (w == {(DW+1){1'b1}}) begin
            hlt = 1;
         end else begin
            op = int'(w[3:0]);
            if (op <= 4) begin
               if (s.size() < 2) flt = 1;
               else begin
                  y = s.pop_back();
                  x = s.pop_back();
                  case (op)
                     0: r = (x + y) % 256;
                     1: r = (x - y + 256) % 256;
                     2: r = x & y;
                     3: r = x | y;
                     default: r = x ^ y;
                  endcase
                  s.push_back(r);
               end
            end else if (op == 5) begin
               if (s.size() == 0 || s.size() == DEPTH) flt = 1;
               else s.push_back(s[$]);
            end else if (op == 6) begin
               if (s.size() == 0) flt = 1;
               else void'(s.pop_back());
            end else if (op == 7) begin
               if (s.size() < 2) flt = 1;
               else begin
                  y = s.pop_back();
                  x = s.pop_back();
                  s.push_back(y);
                  s.push_back(x);
               end
            end else if (op == 8) begin
               if (s.size() < 2) flt = 1;
               else begin
                  y = s.pop_back();
                  x = s.pop_back();
                  if (x == 0) nxt = y % 256;
               end
            end
         end
         if (!hlt && !flt) pc = nxt;
      end
      ok = hlt || flt;
      if (ok && commit) begin
         f.tos   = (s.size() != 0) ? s[$] : 0;
         f.depth = s.size();
         f.pc    = pc;
         f.fault = flt;
         foreach (a[i]) exp_addr_q.push_back(a[i]);
         fin_q.push_back(f);
      end
   endtask

   task automatic run_prog(input int budget, output int cyc);
      bit ok;
      reset = 1'b0;
      mon_en = 0;
      exp_addr_q.delete();
      fin_q.delete();
      repeat (2) @(posedge clk);
      run_model(1, ok);
      check("model_terminates", int'(ok), 1);
      mon_en = 1;
      @(posedge clk);
      #2 reset = 1'b1;
      cyc = 0;
      while (cyc < budget) begin
         @(posedge clk);
         cyc++;
         #1;
         if (done) break;
      end
      check("done_within_budget", int'(done), 1);
      repeat (2) @(posedge clk);
   endtask

   // Memory responder: random or fixed ack latency, spurious acks when idle.
   initial begin
      int lat;
      lat = -1;
      forever begin
         @(negedge clk);
         if (reset && imem_req) begin
            if (lat < 0) lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, max_lat));
            if (lat == 0) begin
               imem_ack  = 1'b1;
               imem_data = prog[imem_addr];
               lat = -1;
            end else begin
               imem_ack  = 1'b0;
               imem_data = (DW+1)'($urandom);
               lat--;
            end
         end else begin
            imem_ack  = spur && ($urandom_range(0, 3) == 0);
            imem_data = (DW+1)'($urandom);
            lat = -1;
         end
      end
   end

   // Monitor: scores each fetch handshake and the final state when done rises.
   initial begin
      int     stall_addr;
      bit     done_seen;
      final_t f;
      stall_addr = -1;
      done_seen  = 0;
      forever begin
         @(negedge clk);
         #1;
         if (!reset) begin
            done_seen  = 0;
            stall_addr = -1;
         end else if (mon_en) begin
            if (imem_req) begin
               if (stall_addr >= 0) check("addr_stable", int'(imem_addr), stall_addr);
               if (imem_ack) begin
                  if (exp_addr_q.size() == 0) check("unexpected_fetch", int'(imem_addr), -1);
                  else check("fetch_addr", int'(imem_addr), exp_addr_q.pop_front());
                  stall_addr = -1;
               end else begin
                  stall_addr = int'(imem_addr);
               end
            end else begin
               stall_addr = -1;
            end
            if (done && !done_seen) begin
               done_seen = 1;
               if (fin_q.size() == 0) check("unexpected_done", 1, 0);
               else begin
                  f = fin_q.pop_front();
                  check("final_tos", int'(tos), f.tos);
                  check("final_depth", int'(depth), f.depth);
                  check("final_fault", int'(fault), f.fault);
                  check("final_pc", int'(imem_addr), f.pc);
                  check("req_low_when_done", int'(imem_req), 0);
                  check("fetches_left", exp_addr_q.size(), 0);
               end
            end
         end
      end
   end

   initial begin
      int  cyc;
      bit  ok;
      bit  seen;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req", int'(imem_req), 0);
      check("rst_done", int'(done), 0);
      check("rst_fault", int'(fault), 0);
      check("rst_depth", int'(depth), 0);
      check("rst_tos", int'(tos), 0);
      check("rst_addr", int'(imem_addr), 0);

      // ADD with single-cycle ack
      fixed_lat = 0; spur = 0;
      foreach (prog[i]) prog[i] = '1;
      prog[0] = psh(5); prog[1] = psh(7); prog[2] = opw(0);
      run_prog(50, cyc);
      check("add_tos", int'(tos), 12);
      check("add_depth", int'(depth), 1);
      check("add_done", int'(done), 1);
      check("add_fault", int'(fault), 0);
      check("add_cycles_le8", int'(cyc <= 8), 1);

      // SUB order and wrap
      spur = 1;
      foreach (prog[i]) prog[i] = '1;
      prog[0] = psh(3); prog[1] = psh(5); prog[2] = opw(1);
      run_prog(100, cyc);
      check("sub_wrap_tos", int'(tos), 254);

      // ADD wrap
      foreach (prog[i]) prog[i] = '1;
      prog[0] = psh(200); prog[1] = psh(100); prog[2] = opw(0);
      run_prog(100, cyc);
      check("add_wrap_tos", int'(tos), 44);

      // Overflow: five pushes into a 4-deep stack
      foreach (prog[i]) prog[i] = '1;
      for (int i = 0; i < 5; i++) prog[i] = psh(1);
      run_prog(100, cyc);
      check("ovf_fault", int'(fault), 1);
      check("ovf_done", int'(done), 1);
      check("ovf_depth", int'(depth), 4);
      check("ovf_pc", int'(imem_addr), 4);

      // Underflow on ADD with one entry
      foreach (prog[i]) prog[i] = '1;
      prog[0] = psh(9); prog[1] = opw(0);
      run_prog(100, cyc);
      check("unf_fault", int'(fault), 1);
      check("unf_depth", int'(depth), 1);
      check("unf_tos", int'(tos), 9);

      // Taken branch
      foreach (prog[i]) prog[i] = '1;
      prog[0] = psh(0); prog[1] = psh(6); prog[2] = opw(8);
      prog[3] = psh(1); prog[4] = psh(1); prog[5] = psh(1);
      run_prog(100, cyc);
      check("brz_pc", int'(imem_addr), 6);
      check("brz_depth", int'(depth), 0);
      check("brz_fault", int'(fault), 0);

      // Five-cycle fetch stall
      fixed_lat = 5;
      foreach (prog[i]) prog[i] = '1;
      prog[0] = psh(42); prog[1] = opw(5);
      run_prog(200, cyc);
      check("stall_tos", int'(tos), 42);
      check("stall_depth", int'(depth), 2);

      // Reset pulsed in EXEC
      fixed_lat = 0; spur = 0;
      foreach (prog[i]) prog[i] = '1;
      prog[0] = psh(1); prog[1] = psh(2); prog[2] = psh(3);
      mon_en = 0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("pre_reset_depth", int'(depth), 1);
      reset = 1'b0;
      #1;
      check("mid_rst_depth", int'(depth), 0);
      check("mid_rst_pc", int'(imem_addr), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_req", int'(imem_req), 0);
      @(posedge clk);
      #2 reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (imem_req && imem_ack) seen = 1;
      end
      check("refetch_seen", int'(seen), 1);
      check("refetch_addr", int'(imem_addr), 0);
      check("refetch_depth", int'(depth), 0);

      // Random programs
      fixed_lat = -1; spur = 1; max_lat = 3;
      for (int t = 0; t < 40; t++) begin
         ok = 0;
         while (!ok) begin
            foreach (prog[i]) begin
               int r;
               r = int'($urandom_range(0, 99));
               if (r < 45) prog[i] = psh(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)));
               else if (r < 55) prog[i] = '1;
               else begin
                  prog[i] = (DW+1)'($urandom);
                  prog[i][DW] = 1'b1;
               end
            end
            run_model(0, ok);
         end
         run_prog(1000, cyc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
